// File: rtl/tile_router_pkg.sv
// Shared packet layout, dimension constants and destination extraction for
// the per-dimension tile write-request router.
package tile_router_pkg;

   localparam int DIM_X = 0;
   localparam int DIM_Y = 1;

   localparam int PKT_DATA_W = 592;
   localparam int PKT_ADDR_W = 37;
   localparam int PKT_SIZE_W = 12;

   typedef struct packed {
      logic [PKT_ADDR_W-1:0] addr;
      logic [PKT_SIZE_W-1:0] size;
      logic [PKT_DATA_W-1:0] data;
   } tile_pkt_t;

   // Coordinate of the destination tile in the routed dimension (unsigned).
   function automatic int unsigned tile_dest(logic [63:0] addr, int unsigned dim,
                                             int unsigned coord_w);
      return 32'((addr >> (dim * coord_w)) & ((64'd1 << coord_w) - 64'd1));
   endfunction

endpackage

// File: rtl/tile_credit_fifo.sv
// Circular input FIFO for one link lane; emits a registered credit pulse for
// every entry freed so the upstream sender can reuse it.
module tile_credit_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         overflow,
   output logic         credit
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr, rptr;
   logic         full, do_pop;

   assign empty    = (wptr == rptr);
   assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   // A full FIFO drops the push even when its head leaves in the same cycle.
   assign overflow = push && full;
   assign head     = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr   <= '0;
         rptr   <= '0;
         credit <= 1'b0;
      end else begin
         credit <= do_pop;
         if (do_pop) rptr <= rptr + (AW+1)'(1);
         if (push && !full) wptr <= wptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push && !full) mem[wptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/tile_dim_credit_router.sv
// One-dimension mesh hop: two credited link lanes plus a round-robin local
// ejection port. Define TILE_ROUTER_FAIR_EN for 2-way round robin on lane outputs.
module tile_dim_credit_router
   import tile_router_pkg::*;
#(
   parameter int          DATA_W   = PKT_DATA_W,
   parameter int          ADDR_W   = PKT_ADDR_W,
   parameter int          SIZE_W   = PKT_SIZE_W,
   parameter int unsigned COORD_W  = 2,
   parameter int unsigned DIM      = DIM_X,
   parameter int unsigned TILE_POS = 0,
   parameter int          DEPTH    = 8,
   localparam int         PKT_W    = ADDR_W + SIZE_W + DATA_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inj_valid,
   output logic                  inj_ready,
   input  logic [DATA_W-1:0]     inj_data,
   input  logic [ADDR_W-1:0]     inj_addr,
   input  logic [SIZE_W-1:0]     inj_size,
   input  logic [1:0]            lin_valid,
   input  logic [1:0][PKT_W-1:0] lin_pkt,
   output logic [1:0]            lin_credit,
   output logic [1:0]            lout_valid,
   output logic [1:0][PKT_W-1:0] lout_pkt,
   input  logic [1:0]            lout_credit,
   output logic                  ej_valid,
   input  logic                  ej_ready,
   output logic [DATA_W-1:0]     ej_data,
   output logic [ADDR_W-1:0]     ej_addr,
   output logic [SIZE_W-1:0]     ej_size,
   output logic                  err
);
   localparam int            CW       = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

   logic [1:0][PKT_W-1:0] head;
   logic [1:0]            empty, ovf, sat, pop;
   logic [1:0]            head_ej, head_fwd, g_pass, g_inj, send;
   logic [2:0]            ej_req, ej_gnt;
   logic [1:0]            rr_ptr;
   logic [PKT_W-1:0]      inj_pkt, ej_pkt;
   logic                  inj_ej, inj_hi, ej_load;

   assign inj_pkt = {inj_addr, inj_size, inj_data};
   assign inj_ej  = tile_dest(64'(inj_addr), DIM, COORD_W) == TILE_POS;
   assign inj_hi  = tile_dest(64'(inj_addr), DIM, COORD_W) > TILE_POS;

   for (genvar l = 0; l < 2; l++) begin : g_lane
      logic [ADDR_W-1:0] haddr;
      logic              inj_cand, cred_ok, vld_q;
      logic [CW-1:0]     cred;
      logic [PKT_W-1:0]  pkt_q;

      tile_credit_fifo #(.W(PKT_W), .DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (lin_valid[l]),
         .push_data (lin_pkt[l]),
         .pop       (pop[l]),
         .head      (head[l]),
         .empty     (empty[l]),
         .overflow  (ovf[l]),
         .credit    (lin_credit[l])
      );

      // Through-traffic never turns around: anything not local keeps its lane.
      assign haddr       = head[l][PKT_W-1 -: ADDR_W];
      assign head_ej[l]  = !empty[l] && (tile_dest(64'(haddr), DIM, COORD_W) == TILE_POS);
      assign head_fwd[l] = !empty[l] && !head_ej[l];
      assign inj_cand    = inj_valid && !inj_ej && (inj_hi == 1'(l));
      assign cred_ok     = (cred != '0);

`ifdef TILE_ROUTER_FAIR_EN
      logic rr_inj;
      always_ff @(posedge clk) begin
         if (rst)            rr_inj <= 1'b0;
         else if (g_pass[l]) rr_inj <= 1'b1;
         else if (g_inj[l])  rr_inj <= 1'b0;
      end
      assign g_pass[l] = cred_ok && head_fwd[l] && !(inj_cand && rr_inj);
      assign g_inj[l]  = cred_ok && inj_cand && !(head_fwd[l] && !rr_inj);
`else
      assign g_pass[l] = cred_ok && head_fwd[l];
      assign g_inj[l]  = cred_ok && inj_cand && !head_fwd[l];
`endif

      assign send[l] = g_pass[l] || g_inj[l];
      assign sat[l]  = lout_credit[l] && !send[l] && (cred == CRED_MAX);
      assign pop[l]  = g_pass[l] || ej_gnt[l];

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
            cred  <= CRED_MAX;
         end else begin
            vld_q <= send[l];
            if (send[l]) pkt_q <= g_pass[l] ? head[l] : inj_pkt;
            if (lout_credit[l] && !send[l] && (cred != CRED_MAX)) cred <= cred + CW'(1);
            else if (!lout_credit[l] && send[l])                  cred <= cred - CW'(1);
         end
      end

      assign lout_valid[l] = vld_q;
      assign lout_pkt[l]   = pkt_q;
   end

   // Ejection: rotate FIFO0 -> FIFO1 -> injection, starting after the last winner.
   assign ej_req  = {inj_valid && inj_ej, head_ej};
   assign ej_load = !ej_valid || ej_ready;

   always_comb begin
      ej_gnt = 3'b000;
      if (ej_load) begin
         case (rr_ptr)
            2'd1: begin
               if (ej_req[1])      ej_gnt = 3'b010;
               else if (ej_req[2]) ej_gnt = 3'b100;
               else if (ej_req[0]) ej_gnt = 3'b001;
            end
            2'd2: begin
               if (ej_req[2])      ej_gnt = 3'b100;
               else if (ej_req[0]) ej_gnt = 3'b001;
               else if (ej_req[1]) ej_gnt = 3'b010;
            end
            default: begin
               if (ej_req[0])      ej_gnt = 3'b001;
               else if (ej_req[1]) ej_gnt = 3'b010;
               else if (ej_req[2]) ej_gnt = 3'b100;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ej_valid <= 1'b0;
         rr_ptr   <= 2'd0;
      end else if (ej_load) begin
         ej_valid <= |ej_gnt;
         if (ej_gnt[0]) begin
            ej_pkt <= head[0];
            rr_ptr <= 2'd1;
         end else if (ej_gnt[1]) begin
            ej_pkt <= head[1];
            rr_ptr <= 2'd2;
         end else if (ej_gnt[2]) begin
            ej_pkt <= inj_pkt;
            rr_ptr <= 2'd0;
         end
      end
   end

   assign {ej_addr, ej_size, ej_data} = ej_pkt;
   assign inj_ready = !rst && ((|g_inj) || ej_gnt[2]);

   always_ff @(posedge clk) begin
      if (rst)                   err <= 1'b0;
      else if ((|ovf) || (|sat)) err <= 1'b1;
   end

endmodule

// File: tb/tb_tile_dim_credit_router.sv
// Randomized bench for tile_dim_credit_router (TILE_POS=1, X dimension) against
// a queue-based transaction model, plus directed cases with literal expectations.
module tb_tile_dim_credit_router;
   import tile_router_pkg::*;

   localparam int DATA_W = 592, ADDR_W = 37, SIZE_W = 12;
   localparam int COORD_W = 2, DIM = 0, TP = 1, DEPTH = 8;
   localparam int PW = ADDR_W + SIZE_W + DATA_W;
   typedef logic [PW-1:0] pkt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inj_valid = 1'b0, inj_ready, ej_valid, ej_ready = 1'b0, err;
   pkt_t inj_p = '0;
   logic [DATA_W-1:0] inj_data, ej_data;
   logic [ADDR_W-1:0] inj_addr, ej_addr;
   logic [SIZE_W-1:0] inj_size, ej_size;
   logic [1:0] lin_valid = 2'b00, lin_credit, lout_valid, lout_credit = 2'b00;
   logic [1:0][PW-1:0] lin_pkt = '0, lout_pkt;

   assign {inj_addr, inj_size, inj_data} = inj_p;

   always #5 clk = ~clk;

   tile_dim_credit_router #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .COORD_W(COORD_W),
      .DIM(DIM), .TILE_POS(TP), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .inj_valid(inj_valid), .inj_ready(inj_ready),
      .inj_data(inj_data), .inj_addr(inj_addr), .inj_size(inj_size),
      .lin_valid(lin_valid), .lin_pkt(lin_pkt), .lin_credit(lin_credit),
      .lout_valid(lout_valid), .lout_pkt(lout_pkt), .lout_credit(lout_credit),
      .ej_valid(ej_valid), .ej_ready(ej_ready),
      .ej_data(ej_data), .ej_addr(ej_addr), .ej_size(ej_size),
      .err(err)
   );

   int n_chk = 0, n_err = 0;
   bit chk_en = 0;

   // Reference model state
   pkt_t mq[2][$];
   int   mcred[2];
   bit   mev, merr;
   pkt_t mep;
   int   mptr;
   bit [1:0] mlv, mlc, mrr;
   pkt_t mlp[2];
   // Decisions for the current cycle
   bit [1:0] gp, gi;
   int   ew;
   bit   eload, exp_ir;

   task automatic chk(string nm, pkt_t act, pkt_t exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int dst(pkt_t p);
      tile_pkt_t t;
      t = p;
      return int'(t.addr[DIM*COORD_W +: COORD_W]);
   endfunction

   function automatic pkt_t mkpkt(int dest, int tag);
      pkt_t p;
      tile_pkt_t t;
      for (int i = 0; i < PW; i++) p[i] = 1'($urandom);
      t = p;
      t.addr[DIM*COORD_W +: COORD_W] = COORD_W'(dest);
      t.data[7:0] = 8'(tag);
      return t;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < 2; l++) begin
         mq[l].delete();
         mcred[l] = DEPTH;
      end
      mev = 0; merr = 0; mptr = 0; mlv = 0; mlc = 0; mrr = 0;
   endtask

   task automatic model_decide();
      bit pc, ic;
      bit req[3];
      int id, c;
      id = dst(inj_p);
      for (int l = 0; l < 2; l++) begin
         pc = mq[l].size() > 0 && dst(mq[l][0]) != TP;
         ic = inj_valid && id != TP && ((id > TP) ? 1 : 0) == l;
         gp[l] = 0; gi[l] = 0;
         if (mcred[l] > 0) begin
`ifdef TILE_ROUTER_FAIR_EN
            if (pc && ic) begin
               if (mrr[l]) gi[l] = 1; else gp[l] = 1;
            end else begin
               gp[l] = pc; gi[l] = ic;
            end
`else
            gp[l] = pc;
            gi[l] = ic && !pc;
`endif
         end
      end
      for (int l = 0; l < 2; l++) req[l] = mq[l].size() > 0 && dst(mq[l][0]) == TP;
      req[2] = inj_valid && id == TP;
      eload = !mev || ej_ready;
      ew = -1;
      if (eload)
         for (int k = 0; k < 3; k++) begin
            c = (mptr + k) % 3;
            if (ew < 0 && req[c]) ew = c;
         end
      exp_ir = !rst && (gi[0] || gi[1] || ew == 2);
   endtask

   task automatic model_update();
      bit full;
      if (rst) begin
         model_reset();
         return;
      end
      for (int l = 0; l < 2; l++) begin
         mlv[l] = gp[l] || gi[l];
         if (mlv[l]) mlp[l] = gp[l] ? mq[l][0] : inj_p;
         if (lout_credit[l] && !mlv[l] && mcred[l] == DEPTH) merr = 1;
         else mcred[l] = mcred[l] + int'(lout_credit[l]) - int'(mlv[l]);
         if (gp[l]) mrr[l] = 1;
         else if (gi[l]) mrr[l] = 0;
      end
      if (eload) begin
         mev = (ew >= 0);
         if (ew == 2) mep = inj_p;
         else if (ew >= 0) mep = mq[ew][0];
         if (ew >= 0) mptr = (ew + 1) % 3;
      end
      for (int l = 0; l < 2; l++) begin
         full = mq[l].size() == DEPTH;
         mlc[l] = gp[l] || ew == l;
         if (mlc[l]) void'(mq[l].pop_front());
         if (lin_valid[l]) begin
            if (full) merr = 1;
            else mq[l].push_back(lin_pkt[l]);
         end
      end
   endtask

   task automatic check_all();
      chk("err", PW'(err), PW'(merr));
      chk("inj_ready", PW'(inj_ready), PW'(exp_ir));
      chk("lout_valid", PW'(lout_valid), PW'(mlv));
      for (int l = 0; l < 2; l++)
         if (mlv[l]) chk($sformatf("lout_pkt%0d", l), lout_pkt[l], mlp[l]);
      chk("lin_credit", PW'(lin_credit), PW'(mlc));
      chk("ej_valid", PW'(ej_valid), PW'(mev));
      if (mev) chk("ej_pkt", {ej_addr, ej_size, ej_data}, mep);
   endtask

   // One clock: inputs are already driven; check, then advance the model.
   task automatic cyc();
      #3;
      model_decide();
      if (chk_en) check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle(int n);
      lin_valid = 2'b00; inj_valid = 1'b0; lout_credit = 2'b00;
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   int cnt;
   int up[2];
   bit [7:0] tags[$];
   pkt_t p;

   initial begin
      #1;
      idle(1);
      chk_en = 1;
      do_reset();
      idle(2);
      chk("rst_lout_valid", PW'(lout_valid), PW'(0));
      chk("rst_ej_valid", PW'(ej_valid), PW'(0));
      chk("rst_err", PW'(err), PW'(0));
      chk("rst_lin_credit", PW'(lin_credit), PW'(0));
      chk("rst_inj_ready", PW'(inj_ready), PW'(0));

      // Injection toward higher coordinate goes out on lane 1 next cycle.
      p = mkpkt(3, 8'h11);
      inj_p = p; inj_valid = 1'b1;
      cyc();
      inj_valid = 1'b0;
      chk("inj_lout_valid", PW'(lout_valid), PW'(2'b10));
      chk("inj_lout_pkt", lout_pkt[1], p);
      lout_credit = 2'b10;
      cyc();
      idle(1);

      // Local packet on lane 0 held in ejection while consumer stalls.
      ej_ready = 1'b0;
      p = mkpkt(1, 8'h22);
      lin_pkt[0] = p; lin_valid = 2'b01;
      cyc();
      lin_valid = 2'b00;
      cnt = 0;
      repeat (5) begin
         cyc();
         cnt += int'(lin_credit[0]);
      end
      chk("hold_ej_valid", PW'(ej_valid), PW'(1));
      chk("hold_ej_pkt", {ej_addr, ej_size, ej_data}, p);
      chk("hold_credit_pulses", PW'(cnt), PW'(1));
      ej_ready = 1'b1;
      cyc();
      chk("drain_ej_valid", PW'(ej_valid), PW'(0));

      // Credit exhaustion: 9 packets, 8 credits.
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
         lin_pkt[1] = mkpkt(3, i); lin_valid = 2'b10;
         cyc();
         cnt += int'(lout_valid[1]);
      end
      lin_valid = 2'b00;
      repeat (4) begin
         cyc();
         cnt += int'(lout_valid[1]);
      end
      chk("credit_limit_sent", PW'(cnt), PW'(8));
      lout_credit = 2'b10;
      cyc();
      lout_credit = 2'b00;
      repeat (2) begin
         cyc();
         cnt += int'(lout_valid[1]);
      end
      chk("credit_return_sent", PW'(cnt), PW'(9));

      // Overflow of a non-draining FIFO (lane 1 has no credit left).
      for (int i = 0; i < 9; i++) begin
         lin_pkt[1] = mkpkt(3, i); lin_valid = 2'b10;
         cyc();
      end
      idle(3);
      chk("overflow_err_sticky", PW'(err), PW'(1));
      do_reset();
      idle(3);
      chk("err_cleared", PW'(err), PW'(0));
      chk("flushed_lout_valid", PW'(lout_valid), PW'(0));

      // Ejection rotation: FIFO0, FIFO1, injection, FIFO0.
      ej_ready = 1'b0;
      lin_pkt[0] = mkpkt(1, 8'hA0); lin_pkt[1] = mkpkt(1, 8'hB0); lin_valid = 2'b11;
      cyc();
      lin_pkt[0] = mkpkt(1, 8'hA1); lin_pkt[1] = mkpkt(1, 8'hB1);
      cyc();
      idle(2);
      ej_ready = 1'b1;
      inj_p = mkpkt(1, 8'hC0); inj_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (ej_valid) tags.push_back(ej_data[7:0]);
         cyc();
         if (exp_ir) inj_valid = 1'b0;
      end
      chk("rr_count", PW'(tags.size()), PW'(4));
      while (tags.size() < 4) tags.push_back(8'h00);
      chk("rr_0", PW'(tags[0]), PW'(8'hA0));
      chk("rr_1", PW'(tags[1]), PW'(8'hB0));
      chk("rr_2", PW'(tags[2]), PW'(8'hC0));
      chk("rr_3", PW'(tags[3]), PW'(8'hA1));
      idle(4);
      do_reset();

      // Credit returned beyond DEPTH saturates and flags an error.
      lout_credit = 2'b01;
      cyc();
      idle(1);
      chk("sat_err", PW'(err), PW'(1));
      do_reset();
      idle(1);

      // Randomized traffic with upstream/downstream credit discipline.
      up[0] = DEPTH; up[1] = DEPTH;
      for (int c = 0; c < 3000; c++) begin
         rst = (c >= 1500 && c < 1502);
         if (c == 1502) begin
            up[0] = DEPTH; up[1] = DEPTH;
         end
         for (int l = 0; l < 2; l++) begin
            up[l] += int'(mlc[l]);
            lin_valid[l] = !rst && up[l] > 0 && $urandom_range(2, 0) == 0;
            if (lin_valid[l]) begin
               up[l]--;
               lin_pkt[l] = mkpkt(int'($urandom_range(3, 0)), c);
            end
            lout_credit[l] = !rst && mcred[l] < DEPTH && $urandom_range(1, 0) == 1;
         end
         ej_ready = $urandom_range(3, 0) != 0;
         if (!(inj_valid && !exp_ir)) begin
            inj_valid = $urandom_range(1, 0) == 1;
            inj_p = mkpkt(int'($urandom_range(3, 0)), c);
         end
         cyc();
      end
      rst = 1'b0;
      idle(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tile_dim_credit_router.md
Name: tile_dim_credit_router

Overview:
- Per-dimension (X or Y) mesh hop stage for the tile cluster write-request network.
- Successor to the fixed-size 2-lane cluster FIFO, generalised in data width, depth and coordinate width.
- Adds credit-based link flow control, a valid/ready local ejection port, and round-robin ejection arbitration.
- One instance per dimension per tile, between the local request source, two neighbour links (lane 0 = toward lower coordinate, lane 1 = toward higher) and the tile's request consumer.

Parameters:
- DATA_W, 592, payload bits per packet.
- ADDR_W, 37, request address bits.
- SIZE_W, 12, size/attribute bits ({shared,exclusive,phymsk}).
- COORD_W, 2, tile coordinate bits per dimension.
- DIM, 0, dimension routed: 0 = X, 1 = Y.
- TILE_POS, 0, this tile's coordinate in DIM.
- DEPTH, 8, entries per input-lane FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- inj_valid  in  1  local request valid.
- inj_ready  out  1  local request accepted this cycle.
- inj_data  in  DATA_W  local payload.
- inj_addr  in  ADDR_W  local address.
- inj_size  in  SIZE_W  local size.
- lin_valid  in  2  per-lane incoming packet valid.
- lin_pkt  in  2x(ADDR_W+SIZE_W+DATA_W)  incoming packet {addr,size,data}.
- lin_credit  out  2  per-lane credit return to upstream, one pulse per freed entry.
- lout_valid  out  2  per-lane outgoing packet valid.
- lout_pkt  out  2x(ADDR_W+SIZE_W+DATA_W)  outgoing packet.
- lout_credit  in  2  per-lane credit return from downstream.
- ej_valid  out  1  ejected request valid.
- ej_ready  in  1  consumer accepts.
- ej_data  out  DATA_W  ejected payload.
- ej_addr  out  ADDR_W  ejected address.
- ej_size  out  SIZE_W  ejected size.
- err  out  1  sticky protocol error.

Interface decisions:
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Routing:
  - Destination coordinate dest = addr[DIM*COORD_W +: COORD_W]; comparison is unsigned.
  - dest == TILE_POS goes to ejection.
  - dest > TILE_POS goes to lane 1; dest < TILE_POS goes to lane 0.
  - A packet arriving on lane l with dest != TILE_POS continues on lane l; it is never turned around.
- Input FIFOs:
  - One circular FIFO per lane, DEPTH entries, with pointers of log2(DEPTH)+1 bits.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - lin_valid pushes unconditionally.
  - A push while full drops the packet and sets err; err clears only on rst.
- Output credits:
  - Per-lane counter, width log2(DEPTH)+1, reset to DEPTH.
  - Decrements on each lout_valid and increments on each lout_credit.
  - Both in the same cycle leaves it unchanged.
  - Increment beyond DEPTH saturates and sets err.
  - Sending requires credit > 0.
- Output lane arbitration, per lane l, each cycle:
  - Candidates: head of FIFO l if it is routed onward, and injection if routed to l.
  - The pass-through head has fixed priority over injection.
  - Winner is sent only if credit > 0.
  - lout_valid and lout_pkt are registered: one cycle from the decision, for 1 cycle.
  - lout_valid is 0 otherwise.
- Ejection:
  - Single output register.
  - Three requesters: FIFO0 head, FIFO1 head, local injection.
  - Round-robin pointer over the three requesters; it advances past the winner on load.
  - The register loads when empty, or when ej_valid & ej_ready (back-to-back throughput of 1/cycle).
  - While ej_valid & !ej_ready, ej_* hold stable.
- Pop and handshakes:
  - A FIFO head pops when it wins either its lane output or ejection.
  - lin_credit[l] pulses for 1 cycle, registered, in the cycle after the pop.
  - inj_ready is combinational: asserted iff injection wins its target arbiter this cycle.
  - inj_data/addr/size are sampled on inj_valid & inj_ready.
- Latency:
  - Link-in to link-out: 2 cycles (FIFO write, then registered send) with credit available.
  - Link-in to ejection: 2 cycles.
  - Injection to link-out or ejection: 1 cycle.
- Reset:
  - FIFOs empty, credits = DEPTH, RR pointer = FIFO0.
  - Outputs after reset: lout_valid=0, lin_credit=0, ej_valid=0, err=0, inj_ready=0.
  - Reset mid-operation discards all queued and in-flight packets; no credits are returned.
- Same-cycle events:
  - Push and pop of the same FIFO in one cycle are both performed; count is unchanged.
  - A full FIFO with a simultaneous pop still overflows; the push is dropped and err is set.

Optional Feature:
- TILE_ROUTER_FAIR_EN.
- When defined: each lane output arbiter uses 2-way round robin between pass-through and injection instead of fixed pass-through priority.
- When undefined: fixed priority as specified in Behaviour; injection may starve under sustained through-traffic.

Decomposition:
- Shared package tile_router_pkg holds:
  - packet struct typedef {addr,size,data} parameterised by the widths above.
  - DIM_X/DIM_Y constants.
  - the dest-extract function.
- One sub-module tile_credit_fifo: circular FIFO with a registered credit-return pulse, instantiated twice.

Test Plan:
- Reset, then idle: credits=8 both lanes, all valids 0, err=0.
- TILE_POS=1: inject dest=3 → lout_valid[1] next cycle with identical packet, lane-1 credit 8→7; lout_credit[1] pulse → back to 8.
- lin_valid[0] with dest=1, ej_ready=0 for 5 cycles → ej_valid held with stable data, lin_credit[0] not pulsed until the pop, then pulsed once.
- Hold lout_credit=0, push 9 packets dest=3 onto lane 1 → 8 forwarded, 9th stays queued; returning one credit sends it.
- 9 pushes into a non-draining FIFO → err=1 and stays 1 until rst.
- FIFO0, FIFO1 and injection all targeting ejection with ej_ready=1 → grants rotate 0,1,inj,0; with TILE_ROUTER_FAIR_EN, injection competing with continuous pass-through gets every second slot.
